// File: rtl/spi_shared_frame_rx.sv
// Dual-port SPI frame receiver sharing one shift buffer.
// Port 0 is broadcast, port 1 is daisy chain with sdo1_out pass-through.
module spi_shared_frame_rx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             sck0_in,
  input  logic             sdi0_in,
  input  logic             cs0_n_in,
  input  logic             sck1_in,
  input  logic             sdi1_in,
  input  logic             cs1_n_in,
  output logic             sdo1_out,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_data_in,
  input  logic             clr_flags_in,
  output logic [WIDTH-1:0] frame_data_out,
  output logic             frame_valid_out,
  output logic             frame_src_out,
  output logic             busy_out,
  output logic             contention_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int S  = SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  logic [S-1:0] sck0_q, sdi0_q, cs0_q;
  logic [S-1:0] sck1_q, sdi1_q, cs1_q;
  logic         sck0_p_q, sck1_p_q;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fdata_q;
  logic             fvalid_q, fsrc_q;
  logic             busy_q, cont_q, cont_d;

  logic rise0, rise1, bit0, bit1, cs0l, cs1l;
  logic shift, sbit, fire, cset;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sck0_q   <= '0;
      sdi0_q   <= '0;
      cs0_q    <= '1;
      sck1_q   <= '0;
      sdi1_q   <= '0;
      cs1_q    <= '1;
      sck0_p_q <= 1'b0;
      sck1_p_q <= 1'b0;
    end else begin
      sck0_q   <= {sck0_q[S-2:0], sck0_in};
      sdi0_q   <= {sdi0_q[S-2:0], sdi0_in};
      cs0_q    <= {cs0_q[S-2:0], cs0_n_in};
      sck1_q   <= {sck1_q[S-2:0], sck1_in};
      sdi1_q   <= {sdi1_q[S-2:0], sdi1_in};
      cs1_q    <= {cs1_q[S-2:0], cs1_n_in};
      sck0_p_q <= sck0_q[S-1];
      sck1_p_q <= sck1_q[S-1];
    end
  end

  // Edge and data are both taken at the last sync stage
  assign rise0 = sck0_q[S-1] & ~sck0_p_q;
  assign rise1 = sck1_q[S-1] & ~sck1_p_q;
  assign bit0  = sdi0_q[S-1];
  assign bit1  = sdi1_q[S-1];
  assign cs0l  = ~cs0_q[S-1];
  assign cs1l  = ~cs1_q[S-1];

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    sbit    = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_in) shreg_d = load_data_in;
        if (cs0l) begin
          state_d = OWN0;
          cnt_d   = '0;
        end else if (cs1l) begin
          state_d = OWN1;
          cnt_d   = '0;
        end
      end
      OWN0: begin
        if (!cs0l) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise0) begin
          shift = 1'b1;
          sbit  = bit0;
        end
      end
      OWN1: begin
        if (!cs1l) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise1) begin
          shift = 1'b1;
          sbit  = bit1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], sbit};
      fire    = (cnt_q == CW'(WIDTH-1));
      cnt_d   = fire ? '0 : cnt_q + 1'b1;
    end
  end

  assign cset = (state_q == OWN0 && cs1l)
             || (state_q == OWN1 && cs0l);

  always_comb begin
    cont_d = cont_q;
    if (clr_flags_in) cont_d = 1'b0;
    if (cset)         cont_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      fdata_q  <= '0;
      fvalid_q <= 1'b0;
      fsrc_q   <= 1'b0;
      busy_q   <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      fvalid_q <= fire;
      busy_q   <= (state_d != IDLE);
      cont_q   <= cont_d;
      if (fire) begin
        fdata_q <= shreg_d;
        fsrc_q  <= (state_q == OWN1);
      end
    end
  end

  assign sdo1_out        = shreg_q[WIDTH-1];
  assign frame_data_out  = fdata_q;
  assign frame_valid_out = fvalid_q;
  assign frame_src_out   = fsrc_q;
  assign busy_out        = busy_q;
  assign contention_out  = cont_q;

endmodule

// File: tb/tb_spi_shared_frame_rx.sv
// Scoreboard bench for spi_shared_frame_rx.
// Directed SPI frames on both ports, monitor pops expected frames.
module tb_spi_shared_frame_rx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sck0, sdi0, cs0_n;
  logic         sck1, sdi1, cs1_n;
  logic         sdo1;
  logic         load;
  logic [W-1:0] load_data;
  logic         clr;
  logic [W-1:0] fdata;
  logic         fvalid, fsrc, busy, cont;

  int total = 0;
  int bad   = 0;

  logic [W:0] q[$];

  spi_shared_frame_rx #(
    .WIDTH(W),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in         (clk),
    .reset_n_in     (rst_n),
    .sck0_in        (sck0),
    .sdi0_in        (sdi0),
    .cs0_n_in       (cs0_n),
    .sck1_in        (sck1),
    .sdi1_in        (sdi1),
    .cs1_n_in       (cs1_n),
    .sdo1_out       (sdo1),
    .load_in        (load),
    .load_data_in   (load_data),
    .clr_flags_in   (clr),
    .frame_data_out (fdata),
    .frame_valid_out(fvalid),
    .frame_src_out  (fsrc),
    .busy_out       (busy),
    .contention_out (cont)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && fvalid) begin
      logic [W:0] e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame got src=%0d data=%h want none",
                 fsrc, fdata);
      end else begin
        e = q.pop_front();
        if ({fsrc, fdata} !== e) begin
          bad++;
          $display("FAIL frame got src=%0d data=%h want src=%0d data=%h",
                   fsrc, fdata, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic send(input int p,
                      input logic [63:0] d,
                      input int n);
    for (int i = 0; i < n; i++) begin
      if (p == 0) sdi0 = d[n-1-i];
      else        sdi1 = d[n-1-i];
      tick(4);
      if (p == 0) sck0 = 1'b1;
      else        sck1 = 1'b1;
      tick(4);
      if (p == 0) sck0 = 1'b0;
      else        sck1 = 1'b0;
    end
  endtask

  task automatic send2(input logic [31:0] d0,
                       input logic [31:0] d1);
    for (int i = 0; i < W; i++) begin
      sdi0 = d0[W-1-i];
      sdi1 = d1[W-1-i];
      tick(4);
      sck0 = 1'b1;
      sck1 = 1'b1;
      tick(4);
      sck0 = 1'b0;
      sck1 = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] lv;
    logic [31:0] dv;
    rst_n     = 1'b0;
    sck0      = 1'b0;
    sdi0      = 1'b0;
    cs0_n     = 1'b1;
    sck1      = 1'b0;
    sdi1      = 1'b0;
    cs1_n     = 1'b1;
    load      = 1'b0;
    load_data = '0;
    clr       = 1'b0;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(fvalid), 32'd0);
    chk("rst_data", fdata, 32'h0);
    chk("rst_sdo", 32'(sdo1), 32'd0);
    chk("rst_cont", 32'(cont), 32'd0);
    rst_n = 1'b1;
    tick(4);

    q.push_back({1'b0, 32'hA5C3_0F71});
    cs0_n = 1'b0;
    tick(6);
    chk("t1_busy_start", 32'(busy), 32'd1);
    send(0, 64'hA5C3_0F71, 32);
    chk("t1_busy_end", 32'(busy), 32'd1);
    cs0_n = 1'b1;
    tick(6);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_drained", q.size(), 32'd0);

    lv = 32'h8000_0001;
    dv = 32'hFFFF_0000;
    load_data = lv;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    q.push_back({1'b1, dv});
    cs1_n = 1'b0;
    tick(6);
    for (int k = 0; k < W; k++) begin
      sdi1 = dv[W-1-k];
      tick(2);
      chk($sformatf("t2_sdo%0d", k), 32'(sdo1), 32'(lv[W-1-k]));
      tick(2);
      sck1 = 1'b1;
      tick(4);
      sck1 = 1'b0;
    end
    tick(2);
    chk("t2_sdo_after", 32'(sdo1), 32'd1);
    cs1_n = 1'b1;
    tick(6);
    chk("t2_drained", q.size(), 32'd0);

    q.push_back({1'b0, 32'h0F0F_1234});
    cs0_n = 1'b0;
    cs1_n = 1'b0;
    tick(6);
    chk("t3_busy", 32'(busy), 32'd1);
    send2(32'h0F0F_1234, 32'hDEAD_BEEF);
    chk("t3_cont", 32'(cont), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    chk("t3_cont_setwins", 32'(cont), 32'd1);
    cs1_n = 1'b1;
    tick(6);
    chk("t3_cont_sticky", 32'(cont), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    chk("t3_cont_clr", 32'(cont), 32'd0);
    cs1_n = 1'b0;
    tick(6);
    chk("t3_cont_reset", 32'(cont), 32'd1);
    cs1_n = 1'b1;
    tick(6);
    cs0_n = 1'b1;
    tick(6);
    chk("t3_drained", q.size(), 32'd0);

    q.push_back({1'b0, 32'h1234_5678});
    q.push_back({1'b0, 32'h9ABC_DEF0});
    cs0_n = 1'b0;
    tick(6);
    send(0, 64'h1234_5678_9ABC_DEF0, 64);
    send(0, 64'hABCDE, 20);
    cs0_n = 1'b1;
    tick(6);
    chk("t4_drained", q.size(), 32'd0);
    chk("t4_last", fdata, 32'h9ABC_DEF0);

    q.push_back({1'b0, 32'h3C3C_5AA5});
    cs0_n = 1'b0;
    tick(6);
    load_data = 32'hFFFF_FFFF;
    load = 1'b1;
    send(0, 64'h3C3C_5AA5, 32);
    load = 1'b0;
    cs0_n = 1'b1;
    tick(6);
    chk("t6_drained", q.size(), 32'd0);

    cs1_n = 1'b0;
    tick(6);
    send(1, 64'hBEEF, 16);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("t5_data0", fdata, 32'h0);
    chk("t5_valid0", 32'(fvalid), 32'd0);
    chk("t5_src0", 32'(fsrc), 32'd0);
    chk("t5_busy0", 32'(busy), 32'd0);
    chk("t5_cont0", 32'(cont), 32'd0);
    chk("t5_sdo0", 32'(sdo1), 32'd0);
    cs1_n = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    q.push_back({1'b1, 32'h0000_00FF});
    cs1_n = 1'b0;
    tick(6);
    send(1, 64'hFF, 32);
    cs1_n = 1'b1;
    tick(6);
    chk("t5_drained", q.size(), 32'd0);
    chk("t5_data", fdata, 32'h0000_00FF);
    chk("t5_src", 32'(fsrc), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
